// File: rtl/dpr_cmd_sequencer.sv
// dpr_cmd_sequencer: walks a host-written command program held in the DPR
// mailbox and replays it as the one-assignment-per-issue handshake that
// model_manager consumes (mm_o strobe, asn_opcode, dpr_pass pointer pass).

`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

package dpr_cmd_pkg;

  // Region pointers are ADDR_W bits; the MSB is the memory-select bit.
  localparam int unsigned ADDR_W = `ADDR_SIZE;

  // Strobe encoding tracks the command code so a decoded header maps 1:1.
  typedef enum logic [3:0] {
    WAIT        = 4'd0,
    ASN_MODEL   = 4'd1,
    ASN_LAYER   = 4'd2,
    ASN_SCRATCH = 4'd3,
    ASN_SGRAD   = 4'd4,
    ASN_WEIGHT  = 4'd5,
    ASN_WGRAD   = 4'd6,
    ASN_BIAS    = 4'd7,
    ASN_BGRAD   = 4'd8,
    ASN_INPUT   = 4'd9,
    ASN_OUTPUT  = 4'd10
  } mm_state;

  // Every 4-bit header opcode value is named so any header field casts cleanly.
  typedef enum logic [3:0] {
    LINEAR     = 4'd0,
    RELU       = 4'd1,
    SOFTMAX    = 4'd2,
    SIGMOID    = 4'd3,
    TANH       = 4'd4,
    CONV2D     = 4'd5,
    MAXPOOL    = 4'd6,
    AVGPOOL    = 4'd7,
    FLATTEN    = 4'd8,
    DROPOUT    = 4'd9,
    BATCHNORM  = 4'd10,
    LEAKY_RELU = 4'd11,
    GELU       = 4'd12,
    ADD        = 4'd13,
    CONCAT     = 4'd14,
    IDENTITY   = 4'd15
  } layer_opcode;

  typedef struct packed {
    logic [ADDR_W-1:0] region_begin;
    logic [ADDR_W-1:0] region_end;
  } mem_handle_t;

endpackage

module dpr_cmd_sequencer
  import dpr_cmd_pkg::*;
#(
  parameter int unsigned CMD_AW = 10,
  parameter int unsigned CMD_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CMD_AW-1:0] base_addr,
  input  logic              mm_ready,
  output logic [CMD_AW-1:0] cmd_raddr,
  output logic              cmd_ren,
  input  logic [CMD_W-1:0]  cmd_rdata,
  output mm_state           mm_o,
  output layer_opcode       asn_opcode,
  output mem_handle_t       dpr_pass,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CMD_AW-1:0] err_addr
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] HDR_RD = 4'd1;
  localparam logic [3:0] HDR_WT = 4'd2;
  localparam logic [3:0] BEG_RD = 4'd3;
  localparam logic [3:0] BEG_WT = 4'd4;
  localparam logic [3:0] END_RD = 4'd5;
  localparam logic [3:0] END_WT = 4'd6;
  localparam logic [3:0] ISSUE  = 4'd7;
  localparam logic [3:0] PASS   = 4'd8;
  localparam logic [3:0] FIN    = 4'd9;
  localparam logic [3:0] ERR    = 4'd10;

  localparam logic [3:0] CMD_NOP     = 4'd0;
  localparam logic [3:0] CMD_LAYER   = 4'd2;
  localparam logic [3:0] CMD_PTR_LO  = 4'd3;
  localparam logic [3:0] CMD_PTR_HI  = 4'd10;
  localparam logic [3:0] CMD_ILL_LO  = 4'd11;
  localparam logic [3:0] CMD_END     = 4'd15;

  localparam logic [CMD_AW-1:0] PTR_MAX = '1;

  logic [3:0]        state;
  logic [CMD_AW-1:0] ptr;
  logic [CMD_AW-1:0] hdr_addr;
  logic              wrap_pend;
  logic [3:0]        cur_cmd;
  logic [ADDR_W-1:0] hold_begin;
  logic [ADDR_W-1:0] hold_end;
  logic              start_pend;
  logic [CMD_AW-1:0] pend_base;

  logic [3:0]        hdr_code;
  logic [3:0]        hdr_op;
  logic [ADDR_W-1:0] ptr_word;
  logic              rd_state;
  logic              cur_is_ptr;
  logic              unused_hdr_bits;

  assign hdr_code        = cmd_rdata[31:28];
  assign hdr_op          = cmd_rdata[27:24];
  assign ptr_word        = cmd_rdata[ADDR_W-1:0];
  assign unused_hdr_bits = ^cmd_rdata[23:ADDR_W];

  assign rd_state   = (state == HDR_RD) || (state == BEG_RD) || (state == END_RD);
  assign cur_is_ptr = (cur_cmd >= CMD_PTR_LO) && (cur_cmd <= CMD_PTR_HI);

  // ptr always holds the next word to fetch, so it doubles as the read address
  assign cmd_raddr = ptr;

  // Read enable and the single-cycle assignment strobe follow the current state
  always_comb begin
    cmd_ren = rd_state && !wrap_pend;
    mm_o    = WAIT;
    if ((state == ISSUE) && mm_ready) begin
      mm_o = mm_state'(cur_cmd);
    end
  end

  // Program walker: fetch, decode, pointer capture, issue and completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      hdr_addr   <= '0;
      wrap_pend  <= 1'b0;
      cur_cmd    <= CMD_NOP;
      hold_begin <= '0;
      hold_end   <= '0;
      start_pend <= 1'b0;
      pend_base  <= '0;
      asn_opcode <= SOFTMAX;
      dpr_pass   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_addr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || start_pend) begin
            ptr        <= start ? base_addr : pend_base;
            wrap_pend  <= 1'b0;
            start_pend <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            state      <= HDR_RD;
          end
        end

        // The top word has already been fetched once wrap_pend is set, so the
        // next fetch is refused here instead of letting ptr roll over to 0.
        HDR_RD, BEG_RD, END_RD: begin
          if (wrap_pend) begin
            err      <= 1'b1;
            err_addr <= ptr;
            busy     <= 1'b0;
            state    <= ERR;
          end else begin
            if (ptr == PTR_MAX) begin
              wrap_pend <= 1'b1;
            end else begin
              ptr <= ptr + CMD_AW'(1);
            end
            if (state == HDR_RD) begin
              hdr_addr <= ptr;
              state    <= HDR_WT;
            end else if (state == BEG_RD) begin
              state <= BEG_WT;
            end else begin
              state <= END_WT;
            end
          end
        end

        HDR_WT: begin
          cur_cmd <= hdr_code;
          if (hdr_code == CMD_NOP) begin
            state <= HDR_RD;
          end else if (hdr_code == CMD_END) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else if (hdr_code >= CMD_ILL_LO) begin
            err      <= 1'b1;
            err_addr <= hdr_addr;
            busy     <= 1'b0;
            state    <= ERR;
          end else if (hdr_code < CMD_PTR_LO) begin
            // Opcode is loaded ahead of the strobe so it is valid while mm_o fires
            if (hdr_code == CMD_LAYER) begin
              asn_opcode <= layer_opcode'(hdr_op);
            end
            state <= ISSUE;
          end else begin
            state <= BEG_RD;
          end
        end

        BEG_WT: begin
          hold_begin <= ptr_word;
          state      <= END_RD;
        end

        END_WT: begin
          hold_end <= ptr_word;
          state    <= ISSUE;
        end

        // dpr_pass is loaded on the strobe edge so it appears in the PASS cycle
        ISSUE: begin
          if (mm_ready) begin
            if (cur_is_ptr) begin
              dpr_pass <= '{region_begin: hold_begin, region_end: hold_end};
              state    <= PASS;
            end else begin
              state <= HDR_RD;
            end
          end
        end

        PASS: begin
          state <= HDR_RD;
        end

        FIN, ERR: begin
          if (start) begin
            start_pend <= 1'b1;
            pend_base  <= base_addr;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpr_cmd_sequencer.sv
// Testbench for dpr_cmd_sequencer: directed programs plus randomized programs
// and mm_ready patterns, checked against a program-walking reference model.

module tb_dpr_cmd_sequencer;
  import dpr_cmd_pkg::*;

  localparam int unsigned AW   = 10;
  localparam int          MAXA = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          mm_ready;
  logic [AW-1:0] cmd_raddr;
  logic          cmd_ren;
  logic [31:0]   cmd_rdata;
  mm_state       mm_o;
  layer_opcode   asn_opcode;
  mem_handle_t   dpr_pass;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;

  logic [31:0] mem [0:MAXA];

  dpr_cmd_sequencer #(.CMD_AW(AW), .CMD_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .mm_ready   (mm_ready),
    .cmd_raddr  (cmd_raddr),
    .cmd_ren    (cmd_ren),
    .cmd_rdata  (cmd_rdata),
    .mm_o       (mm_o),
    .asn_opcode (asn_opcode),
    .dpr_pass   (dpr_pass),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  // DPR read port: data one cycle after the enable
  always @(posedge clk) begin
    if (cmd_ren) cmd_rdata <= mem[cmd_raddr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int q_kind[$];
  int q_op[$];
  int q_beg[$];
  int q_end[$];
  int model_op = 2;   // SOFTMAX after reset
  bit exp_done;
  int exp_erra;
  int exp_cost;
  int last_first_k;

  function automatic logic [31:0] hdr(input int c, input int op);
    logic [3:0] c4;
    logic [3:0] o4;
    c4 = c[3:0];
    o4 = op[3:0];
    return {c4, o4, 24'h0};
  endfunction

  // Walk the program as the host sees it: list of expected assignments,
  // final outcome and stall-free cycle cost.
  task automatic build_expect(input int base);
    int a;
    int c;
    logic [31:0] w;
    logic [31:0] wb;
    logic [31:0] we;
    q_kind.delete(); q_op.delete(); q_beg.delete(); q_end.delete();
    exp_cost = 0;
    a = base;
    while (1) begin
      if (a > MAXA) begin exp_done = 0; exp_erra = MAXA; return; end
      w = mem[a];
      c = int'(w[31:28]);
      if (c == 0) begin
        a += 1; exp_cost += 2;
      end else if (c == 15) begin
        exp_done = 1; exp_cost += 2; return;
      end else if (c >= 11) begin
        exp_done = 0; exp_erra = a; return;
      end else if (c <= 2) begin
        if (c == 2) model_op = int'(w[27:24]);
        q_kind.push_back(c); q_op.push_back(model_op);
        q_beg.push_back(0); q_end.push_back(0);
        a += 1; exp_cost += 3;
      end else begin
        if (a + 2 > MAXA) begin exp_done = 0; exp_erra = MAXA; return; end
        wb = mem[a+1];
        we = mem[a+2];
        q_kind.push_back(c); q_op.push_back(model_op);
        q_beg.push_back(int'(wb[ADDR_W-1:0])); q_end.push_back(int'(we[ADDR_W-1:0]));
        a += 3; exp_cost += 8;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_mm_o"}, mm_o, WAIT);
    check_eq({tag, "_opcode"}, asn_opcode, SOFTMAX);
    check_eq({tag, "_dpr_pass"}, dpr_pass, 0);
    check_eq({tag, "_ren"}, cmd_ren, 0);
    check_eq({tag, "_raddr"}, cmd_raddr, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_err_addr"}, err_addr, 0);
  endtask

  // Run one program. k counts cycles from the first HDR_RD cycle.
  task automatic run_prog(input int base, input int stall, input bit rnd_ready,
                          input bit chk_cost, input int restart_at, input bit pend,
                          input int chain_base);
    int k = 0;
    int busy_cnt = 0;
    int first_k = -1;
    int kind;
    int pb = 0;
    int pe = 0;
    bit seen_busy = 0;
    bit pass_due = 0;
    bit wrapped = 0;
    bit to = 0;
    build_expect(base);
    if (!pend) begin
      @(negedge clk);
      start = 1'b1;
      base_addr = AW'(base);
    end
    while (1) begin
      @(negedge clk);
      start = (k == restart_at);
      if (start) base_addr = AW'($urandom);
      mm_ready = (k < stall) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      if (pass_due) begin
        check_eq("pass_mm_wait", mm_o, WAIT);
        check_eq("pass_begin", dpr_pass.region_begin, pb);
        check_eq("pass_end", dpr_pass.region_end, pe);
        pass_due = 0;
      end
      if (mm_o != WAIT) begin
        if (first_k < 0) first_k = k;
        check_eq("strobe_ready", mm_ready, 1);
        if (q_kind.size() == 0) begin
          check_eq("extra_strobe", mm_o, WAIT);
        end else begin
          kind = q_kind.pop_front();
          check_eq("strobe_kind", mm_o, kind);
          check_eq("strobe_opcode", asn_opcode, q_op.pop_front());
          pb = q_beg.pop_front();
          pe = q_end.pop_front();
          if (kind >= 3) pass_due = 1;
        end
      end
      if (busy) begin busy_cnt++; seen_busy = 1; end
      if (cmd_ren && (int'(cmd_raddr) < base)) wrapped = 1;
      if (seen_busy && (done || err)) break;
      if (k > 3000) begin to = 1; break; end
      k++;
    end
    check_eq("timeout", to, 0);
    check_eq("strobes_missing", q_kind.size(), 0);
    check_eq("done", done, exp_done);
    check_eq("err", err, !exp_done);
    if (!exp_done) check_eq("err_addr", err_addr, exp_erra);
    check_eq("busy_end", busy, 0);
    if (chk_cost && exp_done) check_eq("cycles", busy_cnt, exp_cost);
    check_eq("no_wrap", wrapped, 0);
    last_first_k = first_k;
    if (chain_base >= 0) begin
      start = 1'b1;
      base_addr = AW'(chain_base);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("done_pulse", done, 0);
    check_eq("err_sticky", err, !exp_done);
  endtask

  task automatic put(inout int a, input logic [31:0] w);
    mem[a] = w;
    a++;
  endtask

  task automatic put_ptr(inout int a, input int c, input logic [31:0] b, input logic [31:0] e);
    put(a, hdr(c, 0));
    put(a, b);
    put(a, e);
  endtask

  initial begin
    int a;
    int n;
    int r;
    int base;
    logic [3:0] c;
    for (int i = 0; i <= MAXA; i++) mem[i] = 32'hC000_0000;
    rst = 1'b1; start = 1'b0; mm_ready = 1'b0; base_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Linear + ReLU model program
    a = 'h10;
    put(a, hdr(1, 0)); put(a, hdr(2, 0));
    put_ptr(a, 3, 42, 50);  put_ptr(a, 4, 50, 58);
    put_ptr(a, 5, 5, 34);   put_ptr(a, 6, 58, 87);
    put_ptr(a, 7, 34, 42);  put_ptr(a, 8, 87, 95);
    put(a, hdr(1, 0)); put(a, hdr(2, 1));
    put_ptr(a, 3, 95, 103); put_ptr(a, 4, 103, 111);
    put(a, hdr(1, 0)); put(a, hdr(15, 0));
    run_prog('h10, 0, 0, 1, 2, 0, -1);

    // INPUT/OUTPUT with memory-select MSB set and junk above the pointer field
    a = 'h80;
    put_ptr(a, 9, 32'hABCD_8000, 32'h1234_8007);
    put_ptr(a, 10, 32'h0000_8007, 32'hFFFF_800E);
    put(a, hdr(15, 0));
    run_prog('h80, 0, 0, 1, -1, 0, -1);

    // WEIGHT held at ISSUE for 20 cycles (ISSUE is reached at k=6)
    a = 'h100;
    put_ptr(a, 5, 32'h0000_0123, 32'h0000_0456);
    put(a, hdr(15, 0));
    run_prog('h100, 26, 0, 0, -1, 0, -1);
    check_eq("stall_strobe_cycle", last_first_k, 26);

    // Illegal header at 5, then a start during ERR runs the IO program
    mem[4] = hdr(0, 0);
    mem[5] = hdr(12, 0);
    run_prog(4, 0, 0, 0, -1, 0, 'h80);
    run_prog('h80, 0, 0, 1, -1, 1, -1);

    // No END before the top of program space
    mem[MAXA-1] = hdr(0, 0);
    mem[MAXA]   = hdr(0, 0);
    run_prog(MAXA - 1, 0, 0, 0, -1, 0, -1);
    mem[MAXA-1] = hdr(5, 0);
    mem[MAXA]   = 32'h0000_0042;
    run_prog(MAXA - 1, 0, 0, 0, -1, 0, -1);

    // rst during BEG_WT of the WEIGHT command, then a clean rerun
    @(negedge clk); start = 1'b1; base_addr = AW'('h100); mm_ready = 1'b1;
    @(negedge clk); start = 1'b0;   // HDR_RD
    @(negedge clk);                 // HDR_WT
    @(negedge clk);                 // BEG_RD
    @(negedge clk); rst = 1'b1;     // BEG_WT
    @(negedge clk); #1;
    check_reset("mid_rst");
    rst = 1'b0;
    model_op = 2;
    run_prog('h100, 0, 0, 1, -1, 0, -1);

    // Randomized programs and mm_ready patterns
    for (int i = 0; i < 16; i++) begin
      base = 'h200 + int'($urandom_range(0, 128));
      a = base;
      n = int'($urandom_range(2, 10));
      for (int j = 0; j < n; j++) begin
        r = int'($urandom_range(0, 19));
        c = (r == 19) ? 4'($urandom_range(11, 14)) : 4'($urandom_range(0, 10));
        put(a, {c, 4'($urandom), 24'($urandom)});
        if (c >= 4'd3 && c <= 4'd10) begin
          put(a, $urandom);
          put(a, $urandom);
        end
      end
      put(a, {4'hF, 28'($urandom)});
      if (i % 2 == 0) run_prog(base, 0, 0, 1, -1, 0, -1);
      else            run_prog(base, int'($urandom_range(0, 10)), 1, 0, -1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
